// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: state encoding and counter width shared by the pipeline controller.
package pipeline_ctrl_pkg;
  localparam int STALL_CNT_W = 16;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    HALT     = 2'd3
  } state_e;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/memory requests in, per-stage enables and flushes out.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;
  logic hazard_stall;
  logic branch_taken;
  logic mem_req;
  logic mem_ready;
  logic halt;
  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic [1:0] state;
  logic [STALL_CNT_W-1:0] stall_cycles;
  modport master (
    output hazard_stall, branch_taken, mem_req, mem_ready, halt,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, state, stall_cycles
  );
  modport slave (
    input  hazard_stall, branch_taken, mem_req, mem_ready, halt,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, state, stall_cycles
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: W-bit saturating up-counter with enable and async reset.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = (en && count_q != '1) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt controller for a 5-stage pipeline.
// Defining PIPE_PERF_CNT_EN adds the saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic run_en, hz, if_fl, id_fl, mem_stall, pc_en;
  logic [STALL_CNT_W-1:0] stall_cycles;
  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_en  = 1'b1;
    hz      = 1'b0;
    if_fl   = 1'b0;
    id_fl   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.halt) begin
          run_en  = 1'b0;
          state_d = HALT;
        end else if (mem_stall) begin
          run_en  = 1'b0;
          state_d = MEM_WAIT;
        end else if (bus.branch_taken) begin
          if_fl   = 1'b1;
          id_fl   = 1'b1;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
          state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
        end else if (bus.hazard_stall) begin
          hz    = 1'b1;
          id_fl = 1'b1;
        end
      end
      MEM_WAIT: begin
        run_en  = bus.mem_ready;
        state_d = bus.mem_ready ? RUN : MEM_WAIT;
      end
      FLUSH: begin
        // a pending memory stall freezes the flush sequence in place
        if (mem_stall) begin
          run_en = 1'b0;
        end else begin
          if_fl   = 1'b1;
          id_fl   = 1'b1;
          cnt_d   = cnt_q - 3'(cnt_q != 3'd0);
          state_d = cnt_q <= 3'd1 ? RUN : FLUSH;
        end
      end
      default: run_en = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pc_en           = run_en & ~hz;
  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = pc_en;
  assign bus.id_ex_en    = run_en;
  assign bus.ex_mem_en   = run_en;
  assign bus.mem_wb_en   = run_en;
  assign bus.if_id_flush = if_fl;
  assign bus.id_ex_flush = id_fl;
  assign bus.state       = state_q;
  assign bus.stall_cycles = stall_cycles;
`ifdef PIPE_PERF_CNT_EN
  pipe_sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (~pc_en),
    .count(stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 FLUSH_CYCLES, default 1, number of cycles the FLUSH state holds IF/ID and ID/EX flush; legal range 1..7.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 hazard_stall  input  1  data-hazard stall request from the hazard detection logic.
REQ-005 branch_taken  input  1  EX-stage branch/jump resolved taken.
REQ-006 mem_req  input  1  MEM stage holds a load/store this cycle.
REQ-007 mem_ready  input  1  data memory completes the access this cycle.
REQ-008 halt  input  1  halt instruction reached WB.
REQ-009 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  per-stage register write enables.
REQ-010 if_id_flush, id_ex_flush  output  1 each  load a bubble (NOP, dest 0) into the stage register.
REQ-011 state  output  2  current FSM state: RUN=0, MEM_WAIT=1, FLUSH=2, HALT=3.
REQ-012 stall_cycles  output  16  count of cycles with pc_en=0.

Function
REQ-013 FSM states RUN, MEM_WAIT, FLUSH, HALT; the state register and flush counter are the only sequential state besides stall_cycles.
REQ-014 Outputs are combinational from state and current inputs; no added latency.
REQ-015 Priority in RUN: halt > (mem_req & !mem_ready) > branch_taken > hazard_stall.
REQ-016 RUN, no request: all enables 1, flushes 0.
REQ-017 RUN, halt=1: all enables 0, flushes 0; next state HALT.
REQ-018 RUN, mem_req=1 & mem_ready=0: all enables 0, flushes 0; next state MEM_WAIT.
REQ-019 RUN, mem_req=1 & mem_ready=1: treated as no memory request (single-cycle access).
REQ-020 RUN, branch_taken=1: all enables 1, if_id_flush=1, id_ex_flush=1; load flush counter with FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1, else stay RUN.
REQ-021 RUN, hazard_stall=1 only: pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1.
REQ-022 MEM_WAIT: all enables 0 while mem_ready=0; in the cycle mem_ready=1, all enables 1 and next state RUN.
REQ-023 A branch_taken or hazard_stall in MEM_WAIT is ignored; the frozen stage re-presents it in RUN.
REQ-024 FLUSH: all enables 1, if_id_flush=id_ex_flush=1; counter decrements; exit to RUN when counter is 0.
REQ-025 FLUSH: mem_req & !mem_ready overrides: all enables 0, flushes 0, counter holds, state stays FLUSH.
REQ-026 HALT: all enables 0, flushes 0, sticky until rst.
REQ-027 stall_cycles increments by 1 on each cycle where pc_en=0, saturating at 16'hFFFF.

Reset
REQ-028 rst=1 forces state=RUN, flush counter=0, stall_cycles=0 immediately, independent of clk.
REQ-029 Deasserting rst in any state, including mid MEM_WAIT or FLUSH, resumes in RUN with no pending flush.

Configuration
REQ-030 Macro PIPE_PERF_CNT_EN defined: stall_cycles counter implemented per REQ-027.
REQ-031 Macro PIPE_PERF_CNT_EN undefined: no counter register; stall_cycles tied to 16'h0000.

Structure
REQ-032 Shared package holds the state encoding constants (RUN, MEM_WAIT, FLUSH, HALT) and STALL_CNT_W=16.
REQ-033 One sub-module: pipe_sat_counter (16-bit saturating increment with enable, async reset), instantiated only under PIPE_PERF_CNT_EN.

Verification
REQ-034 hazard_stall=1 for 2 cycles in RUN -> pc_en=if_id_en=0, id_ex_flush=1 both cycles; stall_cycles=2.
REQ-035 FLUSH_CYCLES=3, branch_taken pulse -> flushes high 3 consecutive cycles, state RUN->FLUSH->FLUSH->RUN.
REQ-036 mem_req=1, mem_ready low 4 cycles then high -> all enables 0 for 4 cycles, 1 in the ready cycle, state back to RUN.
REQ-037 branch_taken and hazard_stall together with mem_req & !mem_ready -> MEM_WAIT taken, no flush asserted.
REQ-038 halt=1 -> HALT, all enables 0 for 20 cycles; rst pulse mid-HALT -> state=0, stall_cycles=0 asynchronously.
REQ-039 Hold hazard_stall 70000 cycles -> stall_cycles saturates at 16'hFFFF (16'h0000 without PIPE_PERF_CNT_EN).
